// File: rtl/skew_fifo_bank.sv
// Row FIFO feeding a systolic array edge. Each popped row is fanned out as a
// diagonal wavefront: lane i of a row popped in cycle t is presented in
// cycle t+1+i, with idle lanes driven to zero.
module skew_fifo_bank #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned N_CH   = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [N_CH*DATA_W-1:0] wr_data,
  input  logic                   rd_en,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic [N_CH-1:0]        out_valid,
  output logic                   full,
  output logic                   empty,
  output logic [CNT_W-1:0]       count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned ROW_W = N_CH * DATA_W;

  logic [ROW_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             pop_acc;
  logic             push_acc;
  logic [ROW_W-1:0] rd_row;

  // Status comes straight from registered occupancy, never from wr_en/rd_en.
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  assign rd_row = mem[head_q];

  // Accept decisions; flush suppresses both. A push while empty never
  // bypasses to the read side because pop_acc depends on empty alone.
  always_comb begin
    pop_acc  = rd_en && !empty && !flush;
    push_acc = wr_en && (!full || pop_acc) && !flush;
  end

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (pop_acc) begin
        head_d = (head_q == PTR_W'(DEPTH - 1)) ? '0 : head_q + 1'b1;
      end
      if (push_acc) begin
        tail_d = (tail_q == PTR_W'(DEPTH - 1)) ? '0 : tail_q + 1'b1;
      end
      unique case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (wr_en && !push_acc) overflow_d = 1'b1;
      if (rd_en && !pop_acc)  underflow_d = 1'b1;
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Row storage; contents are don't-care after reset so it carries no reset.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[tail_q] <= wr_data;
    end
  end

  // Per-lane skew: lane i goes through i delay stages plus the output register.
  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    logic [DATA_W-1:0] lane_q;
    logic              lane_v_q;

    if (i == 0) begin : g_direct
      // Lane 0 is registered straight from the popped row.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          lane_v_q <= 1'b0;
          lane_q   <= '0;
        end else if (flush) begin
          lane_v_q <= 1'b0;
          lane_q   <= '0;
        end else begin
          lane_v_q <= pop_acc;
          lane_q   <= pop_acc ? rd_row[0 +: DATA_W] : '0;
        end
      end
    end else begin : g_delay
      logic [DATA_W-1:0] dly_d_q [i];
      logic [i-1:0]      dly_v_q;

      // Delay line for lane i, then zero-injecting output register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dly_v_q  <= '0;
          for (int k = 0; k < i; k++) dly_d_q[k] <= '0;
          lane_v_q <= 1'b0;
          lane_q   <= '0;
        end else if (flush) begin
          dly_v_q  <= '0;
          for (int k = 0; k < i; k++) dly_d_q[k] <= '0;
          lane_v_q <= 1'b0;
          lane_q   <= '0;
        end else begin
          dly_v_q[0] <= pop_acc;
          dly_d_q[0] <= pop_acc ? rd_row[i*DATA_W +: DATA_W] : '0;
          for (int k = 1; k < i; k++) begin
            dly_v_q[k] <= dly_v_q[k-1];
            dly_d_q[k] <= dly_d_q[k-1];
          end
          lane_v_q <= dly_v_q[i-1];
          lane_q   <= dly_v_q[i-1] ? dly_d_q[i-1] : '0;
        end
      end
    end

    assign out_valid[i]                 = lane_v_q;
    assign out_data[i*DATA_W +: DATA_W] = lane_q;
  end

endmodule
